// File: rtl/bus_arbiter_if.sv
// Bundle of the shared bit-serial bus: per-master request/serial lines, the single
// slave port, and the arbiter status outputs.
interface bus_arbiter_if #(
  parameter int M = 2
);
  logic [M-1:0] req;
  logic [M-1:0] m_validIn;
  logic [M-1:0] m_wren;
  logic [M-1:0] m_Address;
  logic [M-1:0] m_DataIn;
  logic [M-1:0] m_BurstEn;
  logic [M-1:0] m_ready;
  logic [M-1:0] m_validOut;
  logic [M-1:0] m_DataOut;
  logic         s_validIn;
  logic         s_wren;
  logic         s_Address;
  logic         s_DataIn;
  logic         s_BurstEn;
  logic         s_ready;
  logic         s_validOut;
  logic         s_DataOut;
  logic [M-1:0] grant;
  logic         busy;
  logic         timeout_err;

  // Arbiter view: takes master requests and slave responses, drives the rest.
  modport slave (
    input  req, m_validIn, m_wren, m_Address, m_DataIn, m_BurstEn,
    input  s_ready, s_validOut, s_DataOut,
    output m_ready, m_validOut, m_DataOut,
    output s_validIn, s_wren, s_Address, s_DataIn, s_BurstEn,
    output grant, busy, timeout_err
  );

  modport master (
    output req, m_validIn, m_wren, m_Address, m_DataIn, m_BurstEn,
    output s_ready, s_validOut, s_DataOut,
    input  m_ready, m_validOut, m_DataOut,
    input  s_validIn, s_wren, s_Address, s_DataIn, s_BurstEn,
    input  grant, busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bit-serial slave port between M masters, with a
// watchdog that reclaims a grant held for TIMEOUT cycles.
module bus_arbiter #(
  parameter int M       = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

  state_t        state;
  logic [M-1:0]  grant_q;
  logic          busy_q;
  logic          terr_q;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [M-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic [PW-1:0] sel;
  logic          req_g;
  logic [M-1:0]  gmask;

  // First asserted request scanning upward from ptr+1 with wrap.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    sel      = '0;
    for (int unsigned i = 1; i <= unsigned'(M); i++) begin
      sel = PW'((32'(ptr) + i) % unsigned'(M));
      if (!pick_any && bus.req[sel]) begin
        pick_any  = 1'b1;
        pick[sel] = 1'b1;
        pick_idx  = sel;
      end
    end
  end

  assign req_g = |(bus.req & grant_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      ptr     <= PW'(M - 1);
      cnt     <= '0;
    end else begin
      terr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            ptr     <= pick_idx;
            cnt     <= '0;
            state   <= OWN;
          end
        end
        OWN: begin
          if (!req_g) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state   <= RELEASE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b1;
            state   <= RELEASE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data path is purely combinational off the registered grant; forced quiet in reset.
  always_comb begin
    gmask          = reset ? '0 : grant_q;
    bus.s_validIn  = |(bus.m_validIn & gmask);
    bus.s_wren     = |(bus.m_wren    & gmask);
    bus.s_Address  = |(bus.m_Address & gmask);
    bus.s_DataIn   = |(bus.m_DataIn  & gmask);
    bus.s_BurstEn  = |(bus.m_BurstEn & gmask);
    bus.m_ready    = gmask & {M{bus.s_ready}};
    bus.m_validOut = gmask & {M{bus.s_validOut}};
    bus.m_DataOut  = gmask & {M{bus.s_DataOut}};
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (M=2, TIMEOUT=16): reset, routing, isolation,
// round-robin order, watchdog release, reset mid-grant and a mock slave exchange.
module tb_bus_arbiter;
  localparam int M  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  bus_arbiter_if #(.M(M)) bus ();

  bus_arbiter #(.M(M), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  wdata;
  logic [7:0]  waddr;
  logic [1:0]  gexp;

  initial begin
    reset          = 1'b1;
    bus.req        = '0;
    bus.m_validIn  = '0;
    bus.m_wren     = '0;
    bus.m_Address  = '0;
    bus.m_DataIn   = '0;
    bus.m_BurstEn  = '0;
    bus.s_ready    = 1'b0;
    bus.s_validOut = 1'b0;
    bus.s_DataOut  = 1'b0;

    // Reset: outputs quiet even with active inputs.
    step();
    bus.m_validIn = 2'b11;
    bus.s_ready   = 1'b1;
    bus.req       = 2'b11;
    step();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    chk("rst_s_validIn", 32'(bus.s_validIn), 0);
    chk("rst_m_ready", 32'(bus.m_ready), 0);

    // Single requester.
    bus.req       = 2'b01;
    bus.m_validIn = 2'b00;
    bus.s_ready   = 1'b0;
    reset         = 1'b0;
    step();
    chk("single_grant", 32'(bus.grant), 32'h1);
    chk("single_busy", 32'(bus.busy), 1);
    bus.m_Address = 2'b01;
    bus.s_DataOut = 1'b1;
    #1;
    chk("route_addr1", 32'(bus.s_Address), 1);
    chk("route_dout1", 32'(bus.m_DataOut), 32'h1);
    bus.m_Address = 2'b00;
    bus.s_DataOut = 1'b0;
    #1;
    chk("route_addr0", 32'(bus.s_Address), 0);
    chk("route_dout0", 32'(bus.m_DataOut), 0);

    // Isolation: master 1 toggles while master 0 owns the bus.
    bus.m_validIn  = 2'b10;
    bus.m_Address  = 2'b10;
    bus.s_validOut = 1'b1;
    bus.s_DataOut  = 1'b1;
    #1;
    chk("iso_s_validIn", 32'(bus.s_validIn), 0);
    chk("iso_s_Address", 32'(bus.s_Address), 0);
    chk("iso_m_validOut", 32'(bus.m_validOut), 32'h1);
    chk("iso_m_DataOut", 32'(bus.m_DataOut), 32'h1);
    bus.m_validIn  = 2'b01;
    #1;
    chk("iso_s_validIn0", 32'(bus.s_validIn), 1);
    bus.m_validIn  = '0;
    bus.m_Address  = '0;
    bus.s_validOut = 1'b0;
    bus.s_DataOut  = 1'b0;
    repeat (5) step();
    chk("single_hold", 32'(bus.grant), 32'h1);

    // Drop: one RELEASE cycle that ignores requests, then IDLE grants.
    bus.req = 2'b00;
    step();
    chk("rel_grant", 32'(bus.grant), 0);
    chk("rel_busy", 32'(bus.busy), 0);
    bus.req = 2'b10;
    step();
    chk("rel_no_sample", 32'(bus.grant), 0);
    step();
    chk("idle_grant_m1", 32'(bus.grant), 32'h2);
    bus.req = 2'b00;
    step();
    step();
    chk("idle_empty", 32'(bus.grant), 0);

    // Round-robin with both requesting: 01,10,01,10 with a 2-cycle gap.
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      gexp = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      chk($sformatf("rr_grant%0d", k), 32'(bus.grant), 32'(gexp));
      repeat (9) step();
      chk($sformatf("rr_hold%0d", k), 32'(bus.grant), 32'(gexp));
      bus.req = bus.req & ~gexp;
      step();
      chk($sformatf("rr_gap_a%0d", k), 32'(bus.grant), 0);
      bus.req = 2'b11;
      step();
      chk($sformatf("rr_gap_b%0d", k), 32'(bus.grant), 0);
    end

    // Watchdog: master 0 holds forever.
    bus.req = 2'b01;
    step();
    chk("to_grant", 32'(bus.grant), 32'h1);
    repeat (15) begin
      step();
      if (bus.timeout_err !== 1'b0) chk("to_early_pulse", 32'(bus.timeout_err), 0);
    end
    chk("to_hold15", 32'(bus.grant), 32'h1);
    step();
    chk("to_drop", 32'(bus.grant), 0);
    chk("to_pulse", 32'(bus.timeout_err), 1);
    bus.req = 2'b11;
    step();
    chk("to_pulse_once", 32'(bus.timeout_err), 0);
    chk("to_idle", 32'(bus.grant), 0);
    step();
    chk("to_next_m1", 32'(bus.grant), 32'h2);

    // Reset mid-grant.
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    step();
    chk("post_rst_m0", 32'(bus.grant), 32'h1);

    // Master 0 write; master 1 waits without preempting.
    wdata = 8'hA5;
    waddr = 8'h12;
    bus.m_validIn = 2'b01;
    bus.m_wren    = 2'b01;
    for (int b = 7; b >= 0; b--) begin
      bus.m_Address = {1'b1, waddr[b]};
      bus.m_DataIn  = {1'b1, wdata[b]};
      #1;
      chk($sformatf("wr_addr%0d", b), 32'(bus.s_Address), 32'(waddr[b]));
      chk($sformatf("wr_data%0d", b), 32'(bus.s_DataIn), 32'(wdata[b]));
      step();
    end
    chk("wr_no_preempt", 32'(bus.grant), 32'h1);
    chk("wr_wren", 32'(bus.s_wren), 1);
    bus.req       = 2'b10;
    bus.m_validIn = 2'b10;
    bus.m_wren    = 2'b00;
    bus.m_Address = 2'b00;
    bus.m_DataIn  = 2'b00;
    step();
    chk("wr_release", 32'(bus.grant), 0);
    step();
    step();
    chk("rd_grant_m1", 32'(bus.grant), 32'h2);
    chk("rd_s_validIn", 32'(bus.s_validIn), 1);
    chk("rd_s_wren", 32'(bus.s_wren), 0);

    // Mock slave returns 0xA5 MSB-first to master 1.
    bus.s_validOut = 1'b1;
    for (int b = 7; b >= 0; b--) begin
      bus.s_DataOut = wdata[b];
      #1;
      chk($sformatf("rd_bit%0d", b), 32'(bus.m_DataOut), 32'({wdata[b], 1'b0}));
      chk($sformatf("rd_valid%0d", b), 32'(bus.m_validOut), 32'h2);
      step();
    end
    bus.s_validOut = 1'b0;
    bus.req        = 2'b00;
    step();
    chk("end_release", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter and signal multiplexer that shares one bit-serial slave port (validIn/wren/Address/DataIn/BurstEn in; ready/validOut/DataOut out) between M masters. It sits between the master-side bus interfaces and a slave instance. It grants the bus to exactly one master at a time and routes that master's serial lines to the slave and the slave's responses back. A watchdog reclaims the bus from a master that holds it too long.

Parameters:
M, 2, number of masters (2..8).
TIMEOUT, 4096, maximum cycles a grant may be held before forced release.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  M  per-master bus request; bit i = master i
m_validIn  in  M  per-master validIn
m_wren  in  M  per-master write enable
m_Address  in  M  per-master serial address bit
m_DataIn  in  M  per-master serial write data bit
m_BurstEn  in  M  per-master burst enable / burst-length bit
m_ready  out  M  slave ready routed to the granted master
m_validOut  out  M  slave validOut routed to the granted master
m_DataOut  out  M  slave DataOut routed to the granted master
s_validIn  out  1  to slave validIn
s_wren  out  1  to slave wren
s_Address  out  1  to slave Address
s_DataIn  out  1  to slave DataIn
s_BurstEn  out  1  to slave BurstEn
s_ready  in  1  from slave ready
s_validOut  in  1  from slave validOut
s_DataOut  in  1  from slave DataOut
grant  out  M  one-hot registered grant
busy  out  1  high while any grant is active
timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, busy=0, timeout_err=0, rr pointer=M-1, so master 0 has first priority. All s_* and m_* outputs are 0 during reset.
- FSM states: IDLE, OWN, RELEASE.
- IDLE: if req is nonzero, select the first asserted req scanning from (ptr+1) mod M upward with wrap. Register grant one-hot, set ptr to the winner, clear the timeout counter, go to OWN. Latency: req sampled at edge t gives grant high after edge t. If req is zero, stay in IDLE with grant=0.
- OWN: grant and busy are held.
  - If req[g] is low, go to RELEASE.
  - Otherwise the counter increments each cycle. When counter reaches TIMEOUT-1 while req[g] is still high, go to RELEASE and pulse timeout_err for the cycle in which RELEASE is entered.
  - Requests from other masters are ignored; there is no preemption.
- RELEASE: grant=0 and busy=0 for exactly one cycle, giving a bus turnaround, then return to IDLE. Requests are not sampled in RELEASE. Minimum gap between two grants is therefore 2 cycles (RELEASE + IDLE).
- After a timeout, the offending master must drop req and re-request. A master still holding req after the timeout is treated as a fresh requester in round-robin order, behind all others.
- Muxing is combinational from the registered grant.
  - s_x = m_x[g] when grant is nonzero, else 0.
  - m_ready[i], m_validOut[i], m_DataOut[i] equal the s_ counterparts when grant[i]=1, else 0.
  - No registering in the data path: zero added latency to the serial protocol.
- Counter width: clog2(TIMEOUT)+1 bits, saturating, never wraps.
- Reset mid-grant: grant drops after that edge, with no RELEASE cycle. The slave must be reset by the same signal.
- Simultaneous req drop and timeout on the same cycle: treated as a normal release, timeout_err=0.
- Masters must hold req for the whole transaction, including burst and read-return phases. Dropping req early truncates the transfer; the arbiter does not protect against this.
- Invariant: grant is always one-hot or zero.

Test Plan:
- Single requester: req=01 at cycle 0 → grant=01 at cycle 1, busy=1. Drop req at cycle 20 → grant=00 at cycle 21 (RELEASE), back in IDLE at 22. During the grant, m_Address[0] is mirrored on s_Address and s_DataOut on m_DataOut[0].
- Round-robin fairness, M=2: req=11 held, each master drops req 10 cycles after its grant. Grant sequence must be 01, 10, 01, 10, with a 2-cycle gap between grants.
- Isolation: master 1 toggles m_validIn/m_Address while grant=01 → s_validIn and s_Address follow master 0 only. m_validOut[1] and m_DataOut[1] remain 0.
- Timeout, TIMEOUT=16: req=01 held forever → grant drops 16 cycles after it rises, timeout_err pulses exactly once. With req=11, master 1 is granted next.
- Reset mid-grant: assert reset while grant=10 → grant=00 and busy=0 next cycle. With req=11 after reset, master 0 wins first.
- End-to-end with slave, M=2: master 0 writes 0xA5 to address 0x012 while master 1 waits on req. Master 1 then reads 0x012 and receives serial 1,0,1,0,0,1,0,1 on m_DataOut[1] with m_validOut[1]=1.
